// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller between an 8-bit unified RAM port and two clients
// (instruction-cache miss path and load/store unit). Serialises each access into byte
// cycles, assembles/disassembles little-endian words and returns a one-cycle completion
// pulse. The LSU has priority over the instruction fetch.
// Optional feature: define MEMCTRL_FLUSH_EN to add the 'clear' rollback input, which
// aborts an in-flight fetch or load (never a store).
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
`ifdef MEMCTRL_FLUSH_EN
  input  logic        clear,
`endif
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        inst_miss,
  input  logic [31:0] inst_pc,
  output logic        inst_rdy,
  output logic [31:0] inst_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  localparam logic [31:0] IoTop = 32'h0003_FFFF;

  typedef enum logic [2:0] {StIdle, StIfetch, StLoad, StStore, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        inst_rdy_q, inst_rdy_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic        flush;
  logic        st_issue;
  logic [2:0]  st_idx;
  logic [1:0]  rd_byte;

`ifdef MEMCTRL_FLUSH_EN
  assign flush = clear;
`else
  assign flush = 1'b0;
`endif

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4; // 3 is illegal and behaves as a word
    endcase
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    return (a >= IO_BASE) && (a <= IoTop);
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    inst_rdy_d  = 1'b0;
    ls_done_d   = 1'b0;
    inst_data_d = inst_data_q;
    ls_rdata_d  = ls_rdata_q;
    st_issue    = 1'b0;
    st_idx      = 3'd0;
    rd_byte     = 2'(cnt_q - 3'd1);

    unique case (state_q)
      StIdle: begin
        mem_wr_d = 1'b0;
        if (!flush && ls_req) begin
          base_d  = ls_addr;
          len_d   = len_to_n(ls_len);
          wdata_d = ls_wdata;
          cnt_d   = 3'd0;
          asm_d   = '0;
          if (ls_wr) begin
            state_d  = StStore;
            st_issue = 1'b1;
            st_idx   = 3'd0;
          end else begin
            state_d = StLoad;
            mem_a_d = ls_addr;
          end
        end else if (!flush && inst_miss) begin
          base_d  = inst_pc;
          len_d   = 3'd4;
          cnt_d   = 3'd0;
          asm_d   = '0;
          state_d = StIfetch;
          mem_a_d = inst_pc;
        end
      end

      StIfetch, StLoad: begin
        mem_wr_d = 1'b0;
        if (flush) begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end else begin
          // cnt_q counts edges since acceptance; RAM data lags the address by two edges.
          cnt_d = cnt_q + 3'd1;
          if (cnt_q + 3'd1 < len_q) begin
            mem_a_d = base_q + 32'(cnt_q) + 32'd1;
          end
          if (cnt_q != 3'd0) begin
            asm_d[{rd_byte, 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == len_q) begin
            state_d = StDone;
            cnt_d   = 3'd0;
            if (state_q == StIfetch) begin
              inst_rdy_d  = 1'b1;
              inst_data_d = asm_d;
            end else begin
              ls_done_d  = 1'b1;
              ls_rdata_d = asm_d;
            end
          end
        end
      end

      StStore: begin
        // A byte presented with mem_wr high is written at this edge, so move to the next.
        st_issue = 1'b1;
        st_idx   = mem_wr_q ? cnt_q + 3'd1 : cnt_q;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared store step: used at acceptance and on every store cycle.
    if (st_issue) begin
      cnt_d = st_idx;
      if (st_idx == len_d) begin
        mem_wr_d  = 1'b0;
        ls_done_d = 1'b1;
        state_d   = StDone;
        cnt_d     = 3'd0;
      end else if (io_buffer_full && is_io(base_d)) begin
        mem_wr_d = 1'b0;
      end else begin
        mem_a_d    = base_d + 32'(st_idx);
        mem_dout_d = wdata_d[{st_idx[1:0], 3'b000} +: 8];
        mem_wr_d   = 1'b1;
      end
    end
  end

  // State register; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      inst_rdy_q  <= 1'b0;
      ls_done_q   <= 1'b0;
      inst_data_q <= '0;
      ls_rdata_q  <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      inst_rdy_q  <= inst_rdy_d;
      ls_done_q   <= ls_done_d;
      inst_data_q <= inst_data_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q;
  assign inst_rdy  = inst_rdy_q;
  assign inst_data = inst_data_q;
  assign ls_done   = ls_done_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: directed steps plus randomized accesses checked against a
// byte-array RAM model and access-level expectations (latency, addresses, data).
`timescale 1ns/1ps
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        inst_miss, inst_rdy;
  logic [31:0] inst_pc, inst_data;
  logic        ls_req, ls_wr, ls_done;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [1:0]  ls_len;
`ifdef MEMCTRL_FLUSH_EN
  logic        clear = 1'b0;
  bit          clear_mid = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] last_inst = '0;
  logic [31:0] last_ls = '0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
`ifdef MEMCTRL_FLUSH_EN
    .clear(clear),
`endif
    .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .inst_miss(inst_miss), .inst_pc(inst_pc), .inst_rdy(inst_rdy), .inst_data(inst_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_len(ls_len),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  // RAM model: 64 KiB aliased, one-edge read latency, stalled by rdy like the DUT.
  logic [7:0]  ram [0:65535];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  function automatic logic [7:0] rd(input logic [31:0] a);
    return ram[a[15:0]];
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) begin
        ram[mem_a[15:0]] <= mem_dout;
        wlog_a.push_back(mem_a);
        wlog_d.push_back(mem_dout);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input bit fetch, input logic [1:0] len);
    if (fetch || len >= 2'd2) return 4;
    return (len == 2'd1) ? 2 : 1;
  endfunction

  // One read access; gap = number of rdy-low cycles inserted after acceptance;
  // hold = keep the request level through the cooldown cycle.
  task automatic do_read(input bit fetch, input logic [31:0] addr, input logic [1:0] len,
                         input int gap, input bit hold);
    int n, cyc, k;
    bit seen;
    logic [31:0] exp;
    n = n_of(fetch, len);
    exp = '0;
    for (int i = 0; i < n; i++) exp[8*i +: 8] = rd(addr + 32'(i));
    if (fetch) begin
      inst_miss = 1'b1; inst_pc = addr;
    end else begin
      ls_req = 1'b1; ls_wr = 1'b0; ls_addr = addr; ls_len = len;
    end
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      seen = fetch ? inst_rdy : ls_done;
      if (!seen && gap == 0) begin
        k = (cyc - 1 < n - 1) ? cyc - 1 : n - 1;
        chk("rd_addr", mem_a, addr + 32'(k));
      end
      if (gap > 0 && cyc >= 2 && cyc <= gap + 1) chk("rd_frozen", mem_a, addr);
      if (cyc == 1) begin
        inst_pc = $urandom; ls_addr = $urandom; ls_len = 2'($urandom);
        if (gap > 0) rdy = 1'b0;
      end
      if (cyc == gap + 1) rdy = 1'b1;
    end
    chk(fetch ? "fetch_lat" : "load_lat", seen ? cyc : -1, n + 2 + gap);
    if (fetch) begin
      chk("inst_data", inst_data, exp);
      chk("ls_rdata_kept", ls_rdata, last_ls);
      last_inst = exp;
    end else begin
      chk("ls_rdata", ls_rdata, exp);
      chk("inst_data_kept", inst_data, last_inst);
      last_ls = exp;
    end
    if (hold) begin
      @(negedge clk);
      chk("hold_no_pulse", fetch ? inst_rdy : ls_done, 0);
      chk("hold_no_access", mem_a, addr + 32'(n - 1));
    end
    inst_miss = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    chk("pulse_clear", fetch ? inst_rdy : ls_done, 0);
    chk("idle_addr", mem_a, addr + 32'(n - 1));
  endtask

  // One store; stall = cycles io_buffer_full is held from acceptance;
  // full_always = keep io_buffer_full high (address expected outside the IO region).
  task automatic do_store(input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] data, input int stall, input bit full_always);
    int n, cyc;
    bit seen;
    n = n_of(1'b0, len);
    wlog_a.delete(); wlog_d.delete();
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = addr; ls_len = len; ls_wdata = data;
    io_buffer_full = full_always || (stall > 0);
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      seen = ls_done;
      if (cyc <= stall) chk("stall_wr", mem_wr, 0);
      if (cyc == stall && !full_always) io_buffer_full = 1'b0;
      if (cyc == 1) begin
        ls_addr = $urandom; ls_wdata = $urandom; ls_len = 2'($urandom);
`ifdef MEMCTRL_FLUSH_EN
        clear = clear_mid;
`endif
      end
    end
`ifdef MEMCTRL_FLUSH_EN
    clear = 1'b0;
`endif
    io_buffer_full = 1'b0;
    chk("store_lat", seen ? cyc : -1, n + 1 + stall);
    chk("store_done_wr", mem_wr, 0);
    chk("store_nwrites", wlog_a.size(), n);
    for (int i = 0; i < n && i < wlog_a.size(); i++) begin
      chk("store_addr", wlog_a[i], addr + 32'(i));
      chk("store_byte", {24'd0, wlog_d[i]}, {24'd0, data[8*i +: 8]});
    end
    chk("ls_rdata_kept", ls_rdata, last_ls);
    ls_req = 1'b0;
    @(negedge clk);
    chk("store_pulse_clear", ls_done, 0);
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [31:0] exp, a, d;
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 37 + 11);
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    inst_miss = 1'b0; inst_pc = '0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_len = '0; ls_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_inst_rdy", inst_rdy, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Instruction fetch, request held through the cooldown cycle.
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'hA0; ram[16'h0103] = 8'h00;
    do_read(1'b1, 32'h100, 2'd0, 0, 1'b1);
    chk("fetch_value", inst_data, 32'h00A0_0513);

    // Half load.
    ram[16'h2001] = 8'h34; ram[16'h2002] = 8'h82;
    do_read(1'b0, 32'h2001, 2'd1, 0, 1'b0);
    chk("half_value", ls_rdata, 32'h0000_8234);

    // Word store.
    do_store(32'h40, 2'd2, 32'hDEAD_BEEF, 0, 1'b0);

    // Arbitration: load and fetch raised together.
    exp = {rd(32'h3), rd(32'h2), rd(32'h1), rd(32'h0)};
    d = {24'd0, rd(32'h10)};
    ls_req = 1'b1; ls_wr = 1'b0; ls_addr = 32'h10; ls_len = 2'd0;
    inst_miss = 1'b1; inst_pc = 32'h0;
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++;
      seen = ls_done;
      if (inst_rdy) chk("arb_fetch_early", inst_rdy, 0);
    end
    chk("arb_load_lat", seen ? cyc : -1, 3);
    chk("arb_load_data", ls_rdata, d);
    last_ls = d;
    ls_req = 1'b0;
    @(negedge clk);
    chk("arb_cooldown_addr", mem_a, 32'h10);
    @(negedge clk);
    chk("arb_fetch_start", mem_a, 32'h0);
    seen = 1'b0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++;
      seen = inst_rdy;
    end
    chk("arb_fetch_lat", seen ? cyc : -1, 5);
    chk("arb_fetch_data", inst_data, exp);
    last_inst = exp;
    inst_miss = 1'b0;
    @(negedge clk);

    // IO stall on a byte store, then IO boundary cases.
    do_store(32'h0003_0000, 2'd0, 32'h0000_0041, 3, 1'b0);
    do_store(32'h0002_FFFF, 2'd0, 32'h0000_0077, 0, 1'b1);
    do_store(32'h0003_FFFE, 2'd1, 32'h0000_1234, 2, 1'b0);

    // Wrap-around addressing, illegal length as word, and rdy freeze.
    do_read(1'b0, 32'hFFFF_FFFE, 2'd3, 0, 1'b0);
    do_store(32'hFFFF_FFFF, 2'd1, 32'h0000_CAFE, 0, 1'b0);
    do_read(1'b0, 32'h0000_0500, 2'd2, 3, 1'b0);

    // Reset in the middle of a store: bytes already written stay written.
    wlog_a.delete(); wlog_d.delete();
    ls_req = 1'b1; ls_wr = 1'b1; ls_addr = 32'h600; ls_len = 2'd2; ls_wdata = 32'h1122_3344;
    repeat (2) @(negedge clk);
    rst = 1'b1; ls_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_wr", mem_wr, 0);
    chk("rstmid_nwrites", wlog_a.size(), 2);
    chk("rstmid_ls_rdata", ls_rdata, 0);
    chk("rstmid_mem_a", mem_a, 0);
    last_inst = '0; last_ls = '0;

`ifdef MEMCTRL_FLUSH_EN
    // Fetch aborted two cycles in.
    inst_miss = 1'b1; inst_pc = 32'h200;
    repeat (2) @(negedge clk);
    clear = 1'b1; inst_miss = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (inst_rdy) seen = 1'b1;
    end
    chk("flush_no_rdy", seen, 0);
    chk("flush_inst_kept", inst_data, last_inst);
    do_read(1'b0, 32'h0000_0204, 2'd2, 0, 1'b0);
    // Store runs to completion despite clear.
    clear_mid = 1'b1;
    do_store(32'h0000_0700, 2'd2, 32'hA5B6_C7D8, 0, 1'b0);
    clear_mid = 1'b0;
`endif

    // Randomized accesses.
    for (int it = 0; it < 30; it++) begin
      a = $urandom & 32'h0000_FFFF;
      d = $urandom;
      case ($urandom_range(0, 2))
        0: do_read(1'b1, a & 32'hFFFF_FFFC, 2'd0, 0, 1'b0);
        1: do_read(1'b0, a, 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1'b0);
        default: do_store(a, 2'($urandom_range(0, 3)), d, 0, 1'b0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the CPU's 8-bit unified RAM port and its two memory clients.
- Clients: the instruction cache miss path (32-bit fetches) and the load/store unit (1/2/4-byte loads and stores).
- Arbitrates between the clients, serialises each access into byte cycles, assembles/disassembles little-endian words, and returns a one-cycle completion pulse.
- Sits directly downstream of the instruction cache: consumes its inst_miss/pc_out, produces inst_rdy/inst_in.

Parameters:
- IO_BASE, 32'h0003_0000, lowest address of the memory-mapped IO region (region is IO_BASE..32'h0003_FFFF).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- rdy  input  1  global ready; low freezes the block (RAM is stalled by the same rdy)
- io_buffer_full  input  1  IO output buffer full
- mem_din  input  8  RAM read data for the address sampled by RAM on the previous edge
- mem_dout  output  8  RAM write data
- mem_a  output  32  RAM address
- mem_wr  output  1  1 = write, 0 = read
- inst_miss  input  1  icache requests fetch (level, held until inst_rdy seen)
- inst_pc  input  32  fetch address (word-aligned)
- inst_rdy  output  1  one-cycle pulse: inst_data valid
- inst_data  output  32  fetched instruction
- ls_req  input  1  LSU request (level, held until ls_done seen)
- ls_wr  input  1  1 = store, 0 = load
- ls_addr  input  32  byte address
- ls_len  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- ls_wdata  input  32  store data, byte 0 = bits [7:0]
- ls_done  output  1  one-cycle completion pulse
- ls_rdata  output  32  load data, zero-extended; sign extension is the LSU's job

Behaviour:
- All outputs registered.
- Reset values: state IDLE; mem_a 0, mem_dout 0, mem_wr 0; inst_rdy 0, ls_done 0; inst_data 0, ls_rdata 0; byte counter 0.
- When rdy is 0: no register changes.
- States:
  - IDLE: accepts a request.
  - IFETCH: instruction fetch in progress.
  - LOAD: load in progress.
  - STORE: store in progress.
  - DONE: one-cycle cooldown.
- Arbitration in IDLE: ls_req wins over inst_miss.
  - Request fields are latched at acceptance; later changes to the inputs are ignored.
  - Byte count n = 1, 2 or 4; IFETCH always uses n = 4.
- Reads (IFETCH/LOAD):
  - Accept edge E0: mem_a = base, mem_wr = 0.
  - Edge E(k+1): mem_a = base + k + 1 while k + 1 < n; otherwise mem_a holds.
  - Edge E(k+2): capture mem_din into byte k of the assembly register.
  - Edge E(n+1): capture last byte, set inst_rdy or ls_done = 1, go to DONE.
  - Word read: pulse is high between E5 and E6.
- inst_data and ls_rdata hold their values until the next completion of the same type.
- Stores:
  - Accept edge E0: mem_a = base, mem_dout = byte 0, mem_wr = 1.
  - Next edges: base + k with byte k.
  - The edge after the write of byte n-1: mem_wr = 0, ls_done = 1, go to DONE.
- IO stall:
  - Applies to a store whose address is in the IO region while io_buffer_full = 1.
  - Hold mem_wr = 0, do not advance the counter, retry each cycle.
  - Applies both at acceptance and mid-store.
- DONE:
  - Completion pulse cleared; requests ignored for this cycle so the client can deassert its level request.
  - Go to IDLE at the next edge.
- Address arithmetic is 32-bit wrap-around (32'hFFFF_FFFF + 1 = 0). No alignment check.
- Reset mid-operation: aborts immediately; a partial store leaves the bytes already written.
- Simultaneous ls_req and inst_miss: the LSU is served first; the fetch starts after that access's DONE cycle.

Optional Feature:
- Macro MEMCTRL_FLUSH_EN.
- When defined:
  - Adds input port clear (1 bit, branch-mispredict rollback).
  - clear = 1 in IFETCH or LOAD: next edge goes to IDLE, mem_wr = 0, no completion pulse, partial data discarded.
  - clear = 1 in IDLE: requests ignored that cycle.
  - STORE is never aborted by clear; it completes normally.
- When not defined: no clear port; every accepted access runs to completion.

Test Plan:
- IFETCH: inst_miss = 1, inst_pc = 0x100, RAM[0x100..0x103] = 13 05 A0 00 -> mem_a steps 0x100..0x103 on E0..E3; inst_rdy high E5-E6 only; inst_data = 0x00A00513; no new access in DONE while inst_miss still 1.
- Half load: ls_req = 1, ls_wr = 0, ls_addr = 0x2001, ls_len = 1, RAM[0x2001] = 0x34, RAM[0x2002] = 0x82 -> ls_done pulse after E3, ls_rdata = 0x00008234.
- Word store: ls_addr = 0x40, ls_wdata = 0xDEADBEEF -> mem_wr = 1 for 4 cycles; (mem_a, mem_dout) = (40,EF), (41,BE), (42,AD), (43,DE); then ls_done = 1 with mem_wr = 0.
- Arbitration: ls_req (byte load, addr 0x10) and inst_miss (pc 0x0) asserted in the same cycle -> load completes first, one DONE cycle, then the fetch starts at mem_a = 0x0.
- IO stall: byte store to 0x30000 with data 0x41, io_buffer_full = 1 for 3 cycles -> mem_wr stays 0 for those cycles, then one write of 0x41, then ls_done.
- MEMCTRL_FLUSH_EN: clear = 1 two cycles into an IFETCH -> no inst_rdy, state IDLE next edge, inst_data unchanged; clear during a word store -> all 4 bytes written and ls_done asserted.
